dcache_ctrl: RTL

//  Direct-mapped, write-back, write-allocate L1 data cache controller for the MEM stage.

---
 rtl/dcache_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate L1 data cache controller.
// A miss stalls the CPU while a dirty victim is written back and the new line fetched.
module dcache_ctrl #(
    parameter int NUM_LINES = 16,
    parameter int LINE_W    = 256,
    parameter int ADDR_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - 5 - IDX_W;
    typedef enum logic [1:0] {IDLE, WB, FETCH, REFILL} state_e;
    state_e               state_q, state_d;
    logic [NUM_LINES-1:0] valid_q, valid_d, dirty_q, dirty_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [TAG_W-1:0]     tag_q [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];
    logic [LINE_W-1:0]    fill_q;
    logic [2:0]           word;
    logic [IDX_W-1:0]     idx;
    logic [TAG_W-1:0]     tag;
    logic                 hit, idle_hit, store_hit, unused_addr;

    assign word        = cpu_addr_i[4:2];
    assign idx         = cpu_addr_i[5 +: IDX_W];
    assign tag         = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign unused_addr = ^cpu_addr_i[1:0];
    assign hit         = cpu_req_i & valid_q[idx] & (tag_q[idx] == tag);
    assign idle_hit    = (state_q == IDLE) & hit;
    assign store_hit   = idle_hit & cpu_we_i;
    assign cpu_stall_o = cpu_req_i & ~idle_hit;
    assign cpu_data_o  = (idle_hit & ~cpu_we_i) ? data_q[idx][{word, 5'b0} +: 32] : '0;
    assign mem_enable_o = (state_q == WB) | (state_q == FETCH);
    assign mem_write_o  = (state_q == WB);
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = (state_q == WB) ? data_q[idx] : '0;

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        unique case (state_q)
            IDLE: begin
                dirty_d[idx] = dirty_q[idx] | store_hit;
                if (cpu_req_i & ~hit) begin
                    state_d    = (valid_q[idx] & dirty_q[idx]) ? WB : FETCH;
                    mem_addr_d = (valid_q[idx] & dirty_q[idx]) ? {tag_q[idx], idx, 5'b0}
                                                               : {tag, idx, 5'b0};
                end
            end
            WB: begin
                state_d    = mem_ack_i ? FETCH : WB;
                mem_addr_d = mem_ack_i ? {tag, idx, 5'b0} : mem_addr_q;
            end
            FETCH:  state_d = mem_ack_i ? REFILL : FETCH;
            REFILL: begin
                valid_d[idx] = 1'b1;
                dirty_d[idx] = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Tag and data arrays are left uninitialised; valid bits guard them.
    always_ff @(posedge clk_i) begin
        if (state_q == FETCH && mem_ack_i) fill_q <= mem_data_i;
        if (state_q == REFILL) begin
            data_q[idx] <= fill_q;
            tag_q[idx]  <= tag;
        end else if (store_hit) begin
            data_q[idx][{word, 5'b0} +: 32] <= cpu_data_i;
        end
    end
endmodule
